// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between fetch (read-only) and data (read/write) requesters.
// Optional ARB_DATA_PRIO_EN: ties always go to the data side instead of alternating round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            r_state;
    state_t            w_nextState;
    owner_t            r_owner;
    owner_t            r_lastOwner;
    owner_t            w_winner;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_weQ;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memDataIn;
    logic              w_grant;
    logic              w_last;
    logic              w_tieToD;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_lastOwner <= OWN_I;
            r_cnt       <= '0;
            r_weQ       <= 1'b0;
            r_memAddr   <= '0;
            r_memDataIn <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_grant) begin
                r_owner     <= w_winner;
                r_lastOwner <= w_winner;
                r_cnt       <= CNT_LOAD;
                r_memAddr   <= (w_winner == OWN_D) ? d_addr : i_addr;
                r_weQ       <= (w_winner == OWN_D) && d_we;
                if (w_winner == OWN_D) begin
                    r_memDataIn <= d_wdata;
                end
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_winner     = OWN_I;
        w_grant      = 1'b0;
        w_last       = 1'b0;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        rdata        = '0;
        busy         = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = r_memAddr;
        mem_data_in  = r_memDataIn;

`ifdef ARB_DATA_PRIO_EN
        // Last owner keeps updating so both builds share one datapath; only the tie rule differs.
        w_tieToD = (r_lastOwner == OWN_I) | 1'b1;
`else
        w_tieToD = (r_lastOwner == OWN_I);
`endif
        if (d_req && (!i_req || w_tieToD)) begin
            w_winner = OWN_D;
        end

        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                busy         = 1'b1;
                w_last       = (r_cnt == '0);
                i_gnt        = (r_owner == OWN_I);
                d_gnt        = (r_owner == OWN_D);
                mem_write_en = r_weQ;
                if (w_last) begin
                    i_done      = (r_owner == OWN_I);
                    d_done      = (r_owner == OWN_D);
                    rdata       = mem_data_out;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule
